pe_operand_feeder: RTL

PE_OPERAND_FEEDER -- requirements
Module: pe_operand_feeder

---
 rtl/pe_operand_feeder_pkg.sv | 19 +
 rtl/pe_operand_feeder_if.sv | 31 +++
 rtl/pe_feed_buffer.sv | 47 ++++
 rtl/pe_operand_feeder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pe_operand_feeder_pkg.sv
// Shared definitions for the systolic operand feeder: default array
// dimensions, sequencer state encoding and counter sizing.
package pe_operand_feeder_pkg;

  localparam int N_DEFAULT = 4;
  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feed_state_e;

  // Cycle counter must hold up to 2N-2 (last skewed stream cycle).
  function automatic int cnt_width(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/pe_operand_feeder_if.sv
// Host-side bus of the operand feeder: buffer load port, stream request
// handshake and the skewed west/north operand edges of the PE array.
interface pe_operand_feeder_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IW = $clog2(N);

  logic            wr_en;
  logic            wr_sel;
  logic [IW-1:0]   wr_row;
  logic [IW-1:0]   wr_col;
  logic [W-1:0]    wr_data;
  logic            start;
  logic            busy;
  logic            done;
  logic [N*W-1:0]  a_out;
  logic [N*W-1:0]  b_out;
  logic [N*N-1:0]  init_out;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  busy, done, a_out, b_out, init_out
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output busy, done, a_out, b_out, init_out
  );

endinterface

// File: rtl/pe_feed_buffer.sv
// N x N operand store with one write port and N parallel read ports.
// Reads see a same-cycle write to the same element, so a stream launched
// on the cycle of a write picks up the new value.
module pe_feed_buffer #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [$clog2(N)-1:0]    wr_row,
  input  logic [$clog2(N)-1:0]    wr_col,
  input  logic [W-1:0]            wr_data,
  input  logic [N*$clog2(N)-1:0]  rd_row,
  input  logic [N*$clog2(N)-1:0]  rd_col,
  output logic [N*W-1:0]          rd_data
);
  localparam int IW = $clog2(N);

  logic [W-1:0] mem [N][N];

  // Element storage, cleared by reset, written one element per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  // Parallel read ports with write-through bypass.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < N; p++) begin
      if (wr_en && (wr_row == rd_row[p*IW +: IW]) && (wr_col == rd_col[p*IW +: IW])) begin
        rd_data[p*W +: W] = wr_data;
      end else begin
        rd_data[p*W +: W] = mem[rd_row[p*IW +: IW]][rd_col[p*IW +: IW]];
      end
    end
  end

endmodule

// File: rtl/pe_operand_feeder.sv
// Skewed operand feeder for an N x N systolic array.
//
//   state  | meaning
//   IDLE   | buffers writable, waiting for start
//   STREAM | t = 0..2N-2, diagonal wavefront of A rows / B columns driven
//   DRAIN  | N-1 zero cycles while the last products settle
//
// Output registers are loaded from the next-state view so stream cycle t
// is visible in the (t+1)th cycle after the start edge.
module pe_operand_feeder
  import pe_operand_feeder_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  pe_operand_feeder_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = cnt_width(N);

  feed_state_e     state, state_nxt;
  logic [CW-1:0]   t, t_nxt;

  logic            buf_a_we, buf_b_we;
  logic [N*IW-1:0] a_rd_row, a_rd_col, b_rd_row, b_rd_col;
  logic [N*W-1:0]  a_rd_data, b_rd_data;
  logic [N-1:0]    lane_ok;
  logic [N*N-1:0]  init_nxt;

  logic [N*W-1:0]  a_q, b_q;
  logic [N*N-1:0]  init_q;
  logic            busy_q, done_q;

  assign buf_a_we = bus.wr_en && (state == IDLE) && !bus.wr_sel;
  assign buf_b_we = bus.wr_en && (state == IDLE) &&  bus.wr_sel;

  pe_feed_buffer #(.N(N), .W(W)) u_buf_a (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_a_we),
    .wr_row  (bus.wr_row),
    .wr_col  (bus.wr_col),
    .wr_data (bus.wr_data),
    .rd_row  (a_rd_row),
    .rd_col  (a_rd_col),
    .rd_data (a_rd_data)
  );

  pe_feed_buffer #(.N(N), .W(W)) u_buf_b (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_b_we),
    .wr_row  (bus.wr_row),
    .wr_col  (bus.wr_col),
    .wr_data (bus.wr_data),
    .rd_row  (b_rd_row),
    .rd_col  (b_rd_col),
    .rd_data (b_rd_data)
  );

  // Sequencer state and cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
    end
  end

  // Next state; the counter restarts at 0 on every state entry.
  always_comb begin
    state_nxt = state;
    t_nxt     = t + CW'(1);
    case (state)
      IDLE: begin
        t_nxt = '0;
        if (bus.start) state_nxt = STREAM;
      end
      STREAM: begin
        if (t == CW'(2*N-2)) begin
          state_nxt = DRAIN;
          t_nxt     = '0;
        end
      end
      DRAIN: begin
        if (t == CW'(N-2)) begin
          state_nxt = IDLE;
          t_nxt     = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        t_nxt     = '0;
      end
    endcase
  end

  // Diagonal addressing: lane i carries A[i][t-i] and B[t-i][i].
  always_comb begin
    a_rd_row = '0;
    a_rd_col = '0;
    b_rd_row = '0;
    b_rd_col = '0;
    lane_ok  = '0;
    init_nxt = '0;
    for (int i = 0; i < N; i++) begin
      a_rd_row[i*IW +: IW] = IW'(i);
      a_rd_col[i*IW +: IW] = IW'(int'(t_nxt) - i);
      b_rd_row[i*IW +: IW] = IW'(int'(t_nxt) - i);
      b_rd_col[i*IW +: IW] = IW'(i);
      lane_ok[i] = (state_nxt == STREAM) && (int'(t_nxt) >= i) && (int'(t_nxt) - i < N);
      for (int j = 0; j < N; j++) begin
        init_nxt[i*N+j] = (state_nxt == STREAM) && (int'(t_nxt) == i + j);
      end
    end
  end

  // Registered outputs, zero-padded outside the valid wavefront.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      init_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        a_q[i*W +: W] <= lane_ok[i] ? a_rd_data[i*W +: W] : '0;
        b_q[i*W +: W] <= lane_ok[i] ? b_rd_data[i*W +: W] : '0;
      end
      init_q <= init_nxt;
      busy_q <= (state_nxt != IDLE);
      done_q <= (state == DRAIN) && (state_nxt == IDLE);
    end
  end

  assign bus.a_out    = a_q;
  assign bus.b_out    = b_q;
  assign bus.init_out = init_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
